// File: rtl/vend_sequencer.sv
// vend_sequencer: accumulates coins, validates a selection against the price
// table, pulses the dispenser, drives the change calculator and returns change
// or a full refund on cancel/timeout.
module vend_sequencer #(
  parameter logic [4:0] PRICE0         = 5'd7,
  parameter logic [4:0] PRICE1         = 5'd12,
  parameter logic [4:0] PRICE2         = 5'd15,
  parameter logic [4:0] PRICE3         = 5'd20,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         CHG_WAIT_MAX   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  input  logic       change_dispense_done,
  input  logic [4:0] change_out,
  output logic [4:0] current_amount_display,
  output logic [4:0] product_price,
  output logic       change_dispense_en,
  output logic       single_change_calculator,
  output logic       product_dispense,
  output logic [1:0] product_id,
  output logic       change_valid,
  output logic [4:0] change_value,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, WAIT_CHG, DONE} state_t;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WT_W = $clog2(CHG_WAIT_MAX + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(CHG_WAIT_MAX - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [WT_W-1:0] wt_cnt_q, wt_cnt_d;
  logic [4:0]      amount_d, price_d, chg_d, sel_price;
  logic [1:0]      id_d;
  logic [5:0]      coin_sum;
  logic            disp_d, en_d, cv_d, rej_d, ins_d, fault_d;
  logic            coin_ok, refund, finish;

  function automatic logic [4:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  // Next-state and next-output logic; every output is the registered copy of its _d value.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    wt_cnt_d = wt_cnt_q;
    amount_d = current_amount_display;
    price_d  = product_price;
    id_d     = product_id;
    chg_d    = change_value;
    fault_d  = fault;
    disp_d   = 1'b0;
    en_d     = 1'b0;
    cv_d     = 1'b0;
    ins_d    = 1'b0;
    coin_ok  = 1'b0;
    refund   = 1'b0;
    finish   = 1'b0;
    coin_sum  = {1'b0, current_amount_display} + {1'b0, coin_value};
    sel_price = price_of(sel_id);
    case (state_q)
      IDLE, COLLECT: begin
        // cancel outranks selection, which outranks a coin in the same cycle
        if (cancel) begin
          refund = (state_q == COLLECT);
        end else if (sel_valid) begin
          to_cnt_d = '0;
          if (current_amount_display >= sel_price) begin
            id_d    = sel_id;
            price_d = sel_price;
            disp_d  = 1'b1;
            state_d = VEND;
          end else begin
            ins_d = 1'b1;
          end
        end else if (coin_valid && (coin_sum <= 6'd31)) begin
          amount_d = coin_sum[4:0];
          to_cnt_d = '0;
          coin_ok  = 1'b1;
          state_d  = COLLECT;
        end else if (state_q == COLLECT) begin
          // quiet cycle: a rejected coin does not restart the timeout
          if (to_cnt_q == TO_LAST) refund = 1'b1;
          else to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (refund) begin
          chg_d    = current_amount_display;
          cv_d     = 1'b1;
          amount_d = 5'd0;
          to_cnt_d = '0;
          state_d  = IDLE;
        end
      end
      VEND: begin
        en_d    = 1'b1;
        state_d = CHANGE;
      end
      CHANGE: begin
        wt_cnt_d = '0;
        state_d  = WAIT_CHG;
      end
      WAIT_CHG: begin
        if (change_dispense_done) begin
          chg_d  = change_out;
          finish = 1'b1;
        end else if (wt_cnt_q == WT_LAST) begin
          // calculator never answered: compute change locally and flag it
          chg_d   = current_amount_display - product_price;
          fault_d = 1'b1;
          finish  = 1'b1;
        end else begin
          wt_cnt_d = wt_cnt_q + WT_W'(1);
        end
        if (finish) begin
          cv_d     = 1'b1;
          amount_d = 5'd0;
          price_d  = 5'd0;
          id_d     = 2'd0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rej_d = coin_valid && !coin_ok;
  end

  // State and output registers; reset abandons any transaction in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                  <= IDLE;
      to_cnt_q                 <= '0;
      wt_cnt_q                 <= '0;
      current_amount_display   <= 5'd0;
      product_price            <= 5'd0;
      product_id               <= 2'd0;
      change_value             <= 5'd0;
      fault                    <= 1'b0;
      product_dispense         <= 1'b0;
      change_dispense_en       <= 1'b0;
      single_change_calculator <= 1'b0;
      change_valid             <= 1'b0;
      coin_reject              <= 1'b0;
      insufficient             <= 1'b0;
    end else begin
      state_q                  <= state_d;
      to_cnt_q                 <= to_cnt_d;
      wt_cnt_q                 <= wt_cnt_d;
      current_amount_display   <= amount_d;
      product_price            <= price_d;
      product_id               <= id_d;
      change_value             <= chg_d;
      fault                    <= fault_d;
      product_dispense         <= disp_d;
      change_dispense_en       <= en_d;
      single_change_calculator <= en_d;
      change_valid             <= cv_d;
      coin_reject              <= rej_d;
      insufficient             <= ins_d;
    end
  end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Top-level sequencing controller for the vending machine. It accumulates inserted coins, validates a product selection against a fixed price table, and pulses the product dispenser. It then drives the change-calculator datapath (amount, price, enable and single-shot trigger) and returns the resulting change, or refunds the full amount on cancel or timeout. It sits between the coin/keypad front end and the change-calculator and dispenser blocks.

## Interface
- PRICE0, 5'd7: price of product 0 (5-bit).
- PRICE1, 5'd12: price of product 1.
- PRICE2, 5'd15: price of product 2.
- PRICE3, 5'd20: price of product 3.
- TIMEOUT_CYCLES, 1000: idle cycles in COLLECT before automatic refund (≥2).
- CHG_WAIT_MAX, 4: cycles to wait for change_dispense_done before fault.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; **one clock, asynchronous assert, active-low**.
- coin_valid  in  1  one-cycle strobe; coin_value is valid.
- coin_value  in  5  coin value in units (1..31).
- sel_valid  in  1  one-cycle strobe; product selected.
- sel_id  in  2  product index 0..3.
- cancel  in  1  one-cycle strobe; abort and refund.
- change_dispense_done  in  1  from change calculator.
- change_out  in  5  from change calculator.
- current_amount_display  out  5  accumulated credit.
- product_price  out  5  price of the latched selection; 0 when none.
- change_dispense_en  out  1  change-calculator enable.
- single_change_calculator  out  1  change-calculator one-shot trigger.
- product_dispense  out  1  one-cycle dispense pulse.
- product_id  out  2  latched selection, valid with product_dispense.
- change_valid  out  1  one-cycle pulse; change_value valid.
- change_value  out  5  change or refund amount returned.
- coin_reject  out  1  one-cycle pulse; coin not accepted.
- insufficient  out  1  one-cycle pulse; selection refused.
- fault  out  1  sticky; calculator failed to answer. Cleared only by reset.

## Operation
- Reset: state IDLE; all outputs 0.
- States: IDLE, COLLECT, VEND, CHANGE, WAIT_CHG, DONE.
- Event priority per cycle: cancel > sel_valid > coin_valid. A lower-priority strobe in the same cycle is dropped. A dropped coin pulses coin_reject.
- Coin in IDLE or COLLECT:
  - If amount + coin_value ≤ 31 (6-bit compare), add it and go to (or stay in) COLLECT.
  - Otherwise pulse coin_reject; amount is unchanged.
- Coin in any other state: coin_reject pulse, no other effect.
- sel_valid in IDLE or COLLECT:
  - If amount ≥ price[sel_id], latch sel_id and price, then go to VEND.
  - Otherwise pulse insufficient and stay in the current state.
- sel_valid in any other state is ignored.
- cancel in COLLECT:
  - change_value = amount, change_valid pulse.
  - amount cleared, go to IDLE.
- cancel in any other state is ignored.
- Timeout: counter resets on every accepted coin or selection attempt. After TIMEOUT_CYCLES consecutive quiet cycles in COLLECT, behave exactly as cancel.
- VEND: product_dispense = 1 and product_id valid for one cycle, then go to CHANGE.
- CHANGE: change_dispense_en = 1 and single_change_calculator = 1 for exactly one cycle, then go to WAIT_CHG.
  - current_amount_display and product_price stay stable from VEND through WAIT_CHG.
- WAIT_CHG:
  - On change_dispense_done = 1, register change_out and go to DONE.
  - After CHG_WAIT_MAX cycles without done:
    - set fault;
    - register amount − price (internal subtraction);
    - go to DONE.
- DONE:
  - change_valid pulse with the registered value.
  - amount and product_price cleared to 0.
  - go to IDLE.
- Zero change (amount == price) still produces a change_valid pulse with value 0.

## Timing
- All outputs are registered.
- Coin strobe at edge N: current_amount_display updated after edge N+1.
- Successful selection sampled at N:
  - product_dispense high during cycle N+1;
  - en/trigger high during cycle N+2;
  - change_dispense_done expected during N+3 (calculator is registered, 1-cycle latency);
  - change_valid high during N+4 at the earliest;
  - back in IDLE at N+5.
- Cancel or timeout: change_valid high the cycle after the triggering event.
- No new coin or selection is accepted from VEND through DONE.
- Asynchronous reset mid-transaction abandons it immediately:
  - outputs go to 0;
  - no change or refund is issued;
  - fault is cleared.

## Test plan
- Insert 5, 5, 5 then select product 1 (12): product_dispense with id=1 at N+1; en+trigger at N+2; calculator returns 3; change_valid with change_value=3 at N+4; amount reads 0 afterwards.
- Insert 5, then select product 0 (7): insufficient pulse, state COLLECT, amount 5. Then cancel: change_valid with 5, back to IDLE.
- Insert 20, then 10 (total 30), then 5: third coin gets coin_reject, amount stays 30. Select product 3: change 10.
- Same cycle: sel_valid (product 0) and coin_valid (10) with amount 7: vend proceeds, coin_reject pulses, change 0.
- Insert 3, then no activity for TIMEOUT_CYCLES: refund change_valid with 3.
- Hold change_dispense_done low after a valid select (amount 15, product 0): after CHG_WAIT_MAX cycles fault=1 and change_valid with 8. Assert rst_n low mid-VEND on a second run: all outputs 0 immediately.
